// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port indices, flit control bits, route FSM states.
package noc_pkg;

   localparam int unsigned NUM_PORTS = 5;

   // One-hot output port bit positions
   localparam int unsigned PORT_L = 0;
   localparam int unsigned PORT_N = 1;
   localparam int unsigned PORT_E = 2;
   localparam int unsigned PORT_S = 3;
   localparam int unsigned PORT_W = 4;

   // Control bits, as offsets from the flit width: head = FLIT_W-1, tail = FLIT_W-2
   localparam int unsigned HEAD_OFS = 1;
   localparam int unsigned TAIL_OFS = 2;

   typedef logic [NUM_PORTS-1:0] port_vec_t;

   typedef enum logic {
      IDLE,
      LOCKED
   } route_state_t;

endpackage

// File: rtl/xy_route_unit_if.sv
// Flit handshake bundle between input buffer, route unit and switch allocator.
interface xy_route_unit_if
   import noc_pkg::*;
#(
   parameter int unsigned FLIT_W = 32
);

   logic [FLIT_W-1:0] in_flit;
   logic              in_valid;
   logic              in_ready;
   logic [FLIT_W-1:0] out_flit;
   logic              out_valid;
   port_vec_t         out_port;
   port_vec_t         out_ready;

   // Route unit side
   modport slave (
      input  in_flit,
      input  in_valid,
      output in_ready,
      output out_flit,
      output out_valid,
      output out_port,
      input  out_ready
   );

   // Environment side (input buffer + allocator)
   modport master (
      output in_flit,
      output in_valid,
      input  in_ready,
      input  out_flit,
      input  out_valid,
      input  out_port,
      output out_ready
   );

endinterface

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X then Y) route decision; pure combinational, shared by all input ports.
module xy_route_calc
   import noc_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0] dest_x_i,
   input  logic [N-1:0] dest_y_i,
   input  logic [N-1:0] local_x_i,
   input  logic [N-1:0] local_y_i,
   output port_vec_t    port_c_o
);

   // Resolve X fully before Y; equal coordinates eject locally
   always_comb begin
      port_c_o = '0;
      if (dest_x_i > local_x_i) begin
         port_c_o[PORT_E] = 1'b1;
      end else if (dest_x_i < local_x_i) begin
         port_c_o[PORT_W] = 1'b1;
      end else if (dest_y_i > local_y_i) begin
         port_c_o[PORT_N] = 1'b1;
      end else if (dest_y_i < local_y_i) begin
         port_c_o[PORT_S] = 1'b1;
      end else begin
         port_c_o[PORT_L] = 1'b1;
      end
   end

endmodule

// File: rtl/xy_route_unit.sv
// Per-input-port XY route stage: locks a port on each head flit and forwards
// registered, port-tagged flits to the switch allocator. FLIT_W must match the
// interface instance.
module xy_route_unit
   import noc_pkg::*;
#(
   parameter int unsigned N      = 3,
   parameter int unsigned FLIT_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N-1:0]     local_x,
   input  logic [N-1:0]     local_y,
   xy_route_unit_if.slave   bus,
   output logic             err_seq,
   output logic [CNT_W-1:0] pkt_count
);

   localparam int unsigned HEAD_BIT = FLIT_W - HEAD_OFS;
   localparam int unsigned TAIL_BIT = FLIT_W - TAIL_OFS;

   route_state_t      state_q, state_d;
   port_vec_t         route_q, route_d;
   logic [FLIT_W-1:0] flit_q,  flit_d;
   logic              valid_q, valid_d;
   port_vec_t         port_q,  port_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic      fire_c;
   logic      ready_c;
   logic      accept_c;
   logic      head_c;
   logic      tail_c;
   port_vec_t calc_c;

   xy_route_calc #(
      .N (N)
   ) u_calc (
      .dest_x_i  (bus.in_flit[2*N-1:N]),
      .dest_y_i  (bus.in_flit[N-1:0]),
      .local_x_i (local_x),
      .local_y_i (local_y),
      .port_c_o  (calc_c)
   );

   // Handshake: a single output register that can reload in the cycle it drains
   assign fire_c   = valid_q & (|(port_q & bus.out_ready));
   assign ready_c  = ~valid_q | fire_c;
   assign accept_c = bus.in_valid & ready_c;
   assign head_c   = bus.in_flit[HEAD_BIT];
   assign tail_c   = bus.in_flit[TAIL_BIT];

   assign bus.in_ready  = ready_c;
   assign bus.out_flit  = flit_q;
   assign bus.out_valid = valid_q;
   assign bus.out_port  = port_q;
   assign err_seq       = err_q;
   assign pkt_count     = cnt_q;

   // Next state: route lock FSM, output register load/drain, tail counter
   always_comb begin
      state_d = state_q;
      route_d = route_q;
      flit_d  = flit_q;
      valid_d = valid_q;
      port_d  = port_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;

      if (fire_c) begin
         valid_d = 1'b0;
         if (flit_q[TAIL_BIT] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (accept_c) begin
         if (head_c) begin
            // A head while locked is a framing error, but the new packet still wins the lock
            err_d   = (state_q == LOCKED);
            route_d = calc_c;
            flit_d  = bus.in_flit;
            port_d  = calc_c;
            valid_d = 1'b1;
            state_d = tail_c ? IDLE : LOCKED;
         end else if (state_q == IDLE) begin
            // Orphan body/tail: nothing to route it by, so drop it
            err_d = 1'b1;
         end else begin
            flit_d  = bus.in_flit;
            port_d  = route_q;
            valid_d = 1'b1;
            if (tail_c) begin
               state_d = IDLE;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         route_q <= '0;
         flit_q  <= '0;
         valid_q <= 1'b0;
         port_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         flit_q  <= flit_d;
         valid_q <= valid_d;
         port_q  <= port_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_xy_route_unit.sv
// Directed bench for xy_route_unit with a queue scoreboard checked by an output monitor.
module tb_xy_route_unit;

   localparam int unsigned N      = 3;
   localparam int unsigned FLIT_W = 32;

   typedef struct packed {
      logic [FLIT_W-1:0] flit;
      logic [4:0]        port;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic [N-1:0] local_x;
   logic [N-1:0] local_y;
   logic         err_seq;
   logic [15:0]  pkt_count;
   logic         err_seq_s;
   logic [1:0]   pkt_count_s;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   xy_route_unit_if #(.FLIT_W(FLIT_W)) bus ();
   xy_route_unit_if #(.FLIT_W(FLIT_W)) bus_s ();

   assign bus_s.in_flit   = bus.in_flit;
   assign bus_s.in_valid  = bus.in_valid;
   assign bus_s.out_ready = bus.out_ready;

   xy_route_unit #(.N(N), .FLIT_W(FLIT_W), .CNT_W(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .local_x   (local_x),
      .local_y   (local_y),
      .bus       (bus),
      .err_seq   (err_seq),
      .pkt_count (pkt_count)
   );

   xy_route_unit #(.N(N), .FLIT_W(FLIT_W), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .reset_n   (reset_n),
      .local_x   (local_x),
      .local_y   (local_y),
      .bus       (bus_s),
      .err_seq   (err_seq_s),
      .pkt_count (pkt_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FLIT_W-1:0] mk(input bit h, input bit t, input int data,
                                           input int dx, input int dy);
      return {h, t, 24'(data), 3'(dx), 3'(dy)};
   endfunction

   // Present a flit until accepted; returns the number of stalled cycles
   task automatic send(input logic [FLIT_W-1:0] f, input bit fwd, input logic [4:0] port,
                       input bit exp_err, output int waits);
      exp_t e;
      bus.in_flit  = f;
      bus.in_valid = 1'b1;
      waits = 0;
      if (fwd) begin
         e.flit = f;
         e.port = port;
         sb.push_back(e);
      end
      @(negedge clk);
      while (!bus.in_ready && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout actual=stalled required=in_ready at %0t", $time);
      end
      @(posedge clk);
      #1;
      chk("err_seq", 64'(err_seq), 64'(exp_err));
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_counts(input int main_exp, input int sat_exp);
      chk("pkt_count", 64'(pkt_count), 64'(main_exp));
      chk("pkt_count_sat", 64'(pkt_count_s), 64'(sat_exp));
   endtask

   // Monitor: compare every departing flit against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && bus.out_valid) begin
            chk("port_nonzero", 64'(|bus.out_port), 64'd1);
            if (|(bus.out_port & bus.out_ready)) begin
               if (sb.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_out actual=%0h required=none at %0t",
                           bus.out_flit, $time);
               end else begin
                  e = sb.pop_front();
                  chk("out_flit", 64'(bus.out_flit), 64'(e.flit));
                  chk("out_port", 64'(bus.out_port), 64'(e.port));
               end
            end
         end
      end
   end

   initial begin
      int w;
      logic [FLIT_W-1:0] f;
      logic [FLIT_W-1:0] pkt_f[4];
      logic [4:0]        pkt_p[4];

      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_flit   = '0;
      bus.out_ready = '0;
      local_x       = 3'd2;
      local_y       = 3'd2;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_flit", 64'(bus.out_flit), 64'd0);
      chk("rst_out_port", 64'(bus.out_port), 64'd0);
      chk("rst_err_seq", 64'(err_seq), 64'd0);
      chk_counts(0, 0);
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // 1: single-flit packet East, one-cycle latency
      bus.out_ready = 5'b00100;
      f = mk(1, 1, 'hA5, 5, 1);
      send(f, 1, 5'b00100, 0, w);
      bus.in_valid = 1'b0;
      chk("t1_latency_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_latency_port", 64'(bus.out_port), 64'b00100);
      drain();
      chk_counts(1, 1);

      // 2: 4-flit packet South, back-to-back; body dest bits must not affect routing
      bus.out_ready = 5'b01000;
      send(mk(1, 0, 'h100, 2, 0), 1, 5'b01000, 0, w);
      chk("t2_wait_head", 64'(w), 64'd0);
      send(mk(0, 0, 'h101, 7, 7), 1, 5'b01000, 0, w);
      chk("t2_wait_body1", 64'(w), 64'd0);
      send(mk(0, 0, 'h102, 0, 5), 1, 5'b01000, 0, w);
      chk("t2_wait_body2", 64'(w), 64'd0);
      send(mk(0, 1, 'h103, 6, 1), 1, 5'b01000, 0, w);
      chk("t2_wait_tail", 64'(w), 64'd0);
      bus.in_valid = 1'b0;
      drain();
      chk_counts(2, 2);

      // 3: Local at (3,3) with stall; non-matching ready bits are ignored
      local_x = 3'd3;
      local_y = 3'd3;
      bus.out_ready = 5'b00000;
      f = mk(1, 1, 'h3C3, 3, 3);
      send(f, 1, 5'b00001, 0, w);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) bus.out_ready = 5'b11110;
         #0;
         chk("t3_in_ready", 64'(bus.in_ready), 64'd0);
         chk("t3_hold_flit", 64'(bus.out_flit), 64'(f));
         chk("t3_hold_port", 64'(bus.out_port), 64'b00001);
         cyc(1);
      end
      bus.out_ready = 5'b00001;
      drain();
      chk_counts(3, 3);

      // 4: body flit in IDLE is dropped with a one-cycle error pulse
      local_x = 3'd2;
      local_y = 3'd2;
      bus.out_ready = 5'b11111;
      send(mk(0, 0, 'h44, 1, 1), 0, 5'b0, 1, w);
      bus.in_valid = 1'b0;
      chk("t4_wait", 64'(w), 64'd0);
      chk("t4_not_fwd", 64'(bus.out_valid), 64'd0);
      cyc(1);
      chk("t4_err_one_cycle", 64'(err_seq), 64'd0);
      chk("t4_still_empty", 64'(bus.out_valid), 64'd0);

      // 5: West lock pre-empted by a new head; lock moves to North
      send(mk(1, 0, 'h50, 0, 2), 1, 5'b10000, 0, w);
      send(mk(0, 0, 'h51, 2, 7), 1, 5'b10000, 0, w);
      send(mk(1, 0, 'h52, 2, 7), 1, 5'b00010, 1, w);
      send(mk(0, 0, 'h53, 0, 2), 1, 5'b00010, 0, w);
      send(mk(0, 1, 'h54, 4, 0), 1, 5'b00010, 0, w);
      bus.in_valid = 1'b0;
      drain();
      chk_counts(4, 3);

      // 6: async reset with a flit held, then broken-packet flits dropped
      bus.out_ready = 5'b00000;
      send(mk(1, 0, 'h60, 5, 1), 1, 5'b00100, 0, w);
      bus.in_valid = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_rst_port", 64'(bus.out_port), 64'd0);
      chk("t6_rst_flit", 64'(bus.out_flit), 64'd0);
      chk_counts(0, 0);
      sb.delete();
      cyc(1);
      reset_n = 1'b1;
      bus.out_ready = 5'b11111;
      cyc(1);
      send(mk(0, 0, 'h61, 5, 1), 0, 5'b0, 1, w);
      send(mk(0, 1, 'h62, 5, 1), 0, 5'b0, 1, w);
      bus.in_valid = 1'b0;
      chk("t6_dropped", 64'(bus.out_valid), 64'd0);

      // Saturation: four more single-flit packets in all four directions
      pkt_f[0] = mk(1, 1, 'h70, 5, 1); pkt_p[0] = 5'b00100;
      pkt_f[1] = mk(1, 1, 'h71, 0, 2); pkt_p[1] = 5'b10000;
      pkt_f[2] = mk(1, 1, 'h72, 2, 7); pkt_p[2] = 5'b00010;
      pkt_f[3] = mk(1, 1, 'h73, 2, 0); pkt_p[3] = 5'b01000;
      for (int i = 0; i < 4; i++) begin
         send(pkt_f[i], 1, pkt_p[i], 0, w);
      end
      bus.in_valid = 1'b0;
      drain();
      chk_counts(4, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
